// File: rtl/mm_result_collector.sv
// mm_result_collector: assembles per-lane result writes into rows and streams
// completed rows in order. MM_RESULT_ERR_CHECK_EN drops and flags double writes.
module mm_result_collector #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 32,
  parameter int COL_NUM    = 32,
  localparam int ROW_ADDR_WIDTH = $clog2(ROW_NUM)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [DATA_WIDTH*COL_NUM-1:0]      row_data_in,
  input  logic [ROW_ADDR_WIDTH*COL_NUM-1:0]  row_wraddr,
  input  logic [COL_NUM-1:0]                 row_wr_en,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*COL_NUM-1:0]      out_data,
  output logic [ROW_ADDR_WIDTH-1:0]          out_row,
  output logic [ROW_ADDR_WIDTH:0]            rows_done,
  output logic                               done,
  output logic                               err
);

  logic [DATA_WIDTH*COL_NUM-1:0] row_buf [ROW_NUM];
  logic [COL_NUM-1:0]            fill_q  [ROW_NUM];
  logic [ROW_ADDR_WIDTH-1:0]     rd_row;
  logic [ROW_ADDR_WIDTH:0]       rows_done_q;
  logic                          done_q;
  logic [ROW_ADDR_WIDTH-1:0]     lane_addr [COL_NUM];
  logic [COL_NUM-1:0]            wr_ok;
  logic                          xfer;

  assign out_valid = (&fill_q[rd_row]) & ~done_q;
  assign out_data  = row_buf[rd_row];
  assign out_row   = rd_row;
  assign rows_done = rows_done_q;
  assign done      = done_q;
  assign xfer      = out_valid & out_ready;

  // Split the packed lane address bus into one row index per lane.
  always_comb begin
    for (int j = 0; j < COL_NUM; j++) begin
      lane_addr[j] = row_wraddr[j*ROW_ADDR_WIDTH +: ROW_ADDR_WIDTH];
    end
  end

`ifdef MM_RESULT_ERR_CHECK_EN
  logic [COL_NUM-1:0] dbl;
  logic               err_q;

  // A lane write is taken only if its fill bit is clear; otherwise flag it.
  always_comb begin
    wr_ok = '0;
    dbl   = '0;
    for (int j = 0; j < COL_NUM; j++) begin
      if (row_wr_en[j] && !start) begin
        if (fill_q[lane_addr[j]][j]) dbl[j] = 1'b1;
        else                         wr_ok[j] = 1'b1;
      end
    end
  end

  // Sticky double-write flag, cleared only by start or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      err_q <= 1'b0;
    else if (start)  err_q <= 1'b0;
    else if (|dbl)   err_q <= 1'b1;
  end

  assign err = err_q;
`else
  // Without checking, every strobed lane overwrites; start drops writes.
  always_comb begin
    wr_ok = row_wr_en & {COL_NUM{~start}};
  end

  assign err = 1'b0;
`endif

  // Row buffer, fill bitmap and read-side bookkeeping; transfer clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        row_buf[r] <= '0;
        fill_q[r]  <= '0;
      end
      rd_row      <= '0;
      rows_done_q <= '0;
      done_q      <= 1'b0;
    end else if (start) begin
      for (int r = 0; r < ROW_NUM; r++) begin
        fill_q[r] <= '0;
      end
      rd_row      <= '0;
      rows_done_q <= '0;
      done_q      <= 1'b0;
    end else begin
      for (int j = 0; j < COL_NUM; j++) begin
        if (wr_ok[j]) begin
          row_buf[lane_addr[j]][j*DATA_WIDTH +: DATA_WIDTH]
            <= row_data_in[j*DATA_WIDTH +: DATA_WIDTH];
          fill_q[lane_addr[j]][j] <= 1'b1;
        end
      end
      if (xfer) begin
        fill_q[rd_row] <= '0;
        if (rd_row == ROW_ADDR_WIDTH'(ROW_NUM - 1)) rd_row <= '0;
        else                                        rd_row <= rd_row + 1'b1;
        rows_done_q <= rows_done_q + 1'b1;
        if (rows_done_q == (ROW_ADDR_WIDTH + 1)'(ROW_NUM - 1)) done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mm_result_collector.sv
// tb_mm_result_collector: table vectors, corner sequences and random traffic
// against an array-based model of the row collector (4x4 tile, 8-bit data).
module tb_mm_result_collector;

  localparam int DW = 8;
  localparam int RN = 4;
  localparam int CN = 4;
  localparam int AW = 2;
`ifdef MM_RESULT_ERR_CHECK_EN
  localparam bit ERR_CHK = 1'b1;
`else
  localparam bit ERR_CHK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [DW*CN-1:0] row_data_in;
  logic [AW*CN-1:0] row_wraddr;
  logic [CN-1:0]   row_wr_en;
  logic            out_valid;
  logic            out_ready;
  logic [DW*CN-1:0] out_data;
  logic [AW-1:0]   out_row;
  logic [AW:0]     rows_done;
  logic            done;
  logic            err;

  mm_result_collector #(
    .DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .row_data_in(row_data_in), .row_wraddr(row_wraddr),
    .row_wr_en(row_wr_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .rows_done(rows_done),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_buf  [RN][CN];
  bit         m_fill [RN][CN];
  int         m_rd;
  int         m_cnt;
  bit         m_done;
  bit         m_err;

  typedef struct {
    bit          st;
    logic [3:0]  en;
    logic [7:0]  ad;
    logic [31:0] dt;
    bit          rdy;
    bit          ev;
    logic [1:0]  er;
    logic [31:0] ed;
    logic [2:0]  erd;
    bit          edn;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit m_valid();
    bit full = 1'b1;
    for (int j = 0; j < CN; j++) full &= m_fill[m_rd][j];
    return full && !m_done;
  endfunction

  function automatic logic [31:0] m_data();
    logic [31:0] d;
    for (int j = 0; j < CN; j++) d[j*8 +: 8] = m_buf[m_rd][j];
    return d;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < RN; r++)
      for (int j = 0; j < CN; j++) begin
        m_buf[r][j]  = 8'h00;
        m_fill[r][j] = 1'b0;
      end
    m_rd = 0; m_cnt = 0; m_done = 0; m_err = 0;
  endtask

  task automatic check_model();
    chk("valid", out_valid, m_valid());
    chk("row", out_row, m_rd);
    chk("data", out_data, m_data());
    chk("rows_done", rows_done, m_cnt);
    chk("done", done, m_done);
    chk("err", err, m_err);
  endtask

  // One clock: drive at negedge, advance model, compare #1 after posedge.
  task automatic step(input bit st, input logic [3:0] en,
                      input logic [7:0] ad, input logic [31:0] dt,
                      input bit rdy);
    bit xf;
    int a;
    start = st; row_wr_en = en; row_wraddr = ad;
    row_data_in = dt; out_ready = rdy;
    if (st) begin
      for (int r = 0; r < RN; r++)
        for (int j = 0; j < CN; j++) m_fill[r][j] = 1'b0;
      m_rd = 0; m_cnt = 0; m_done = 0; m_err = 0;
    end else begin
      xf = m_valid() && rdy;
      for (int j = 0; j < CN; j++) begin
        if (en[j]) begin
          a = int'(ad[j*2 +: 2]);
          if (m_fill[a][j]) begin
            if (ERR_CHK) m_err = 1'b1;
            else         m_buf[a][j] = dt[j*8 +: 8];
          end else begin
            m_buf[a][j]  = dt[j*8 +: 8];
            m_fill[a][j] = 1'b1;
          end
        end
      end
      if (xf) begin
        for (int j = 0; j < CN; j++) m_fill[m_rd][j] = 1'b0;
        m_rd = (m_rd + 1) % RN;
        m_cnt++;
        if (m_cnt == RN) m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl [13];
    bit   found;

    tbl[0]  = '{0, 4'hf, 8'h00, 32'h04030201, 1, 1, 2'd0, 32'h04030201, 3'd0, 0};
    tbl[1]  = '{0, 4'h0, 8'h00, 32'h00000000, 1, 0, 2'd1, 32'h00000000, 3'd1, 0};
    tbl[2]  = '{0, 4'h1, 8'h01, 32'h00000010, 1, 0, 2'd1, 32'h00000010, 3'd1, 0};
    tbl[3]  = '{0, 4'h2, 8'h04, 32'h00001100, 1, 0, 2'd1, 32'h00001110, 3'd1, 0};
    tbl[4]  = '{0, 4'h4, 8'h10, 32'h00120000, 1, 0, 2'd1, 32'h00121110, 3'd1, 0};
    tbl[5]  = '{0, 4'h8, 8'h40, 32'h13000000, 1, 1, 2'd1, 32'h13121110, 3'd1, 0};
    tbl[6]  = '{0, 4'h0, 8'h00, 32'h00000000, 1, 0, 2'd2, 32'h00000000, 3'd2, 0};
    tbl[7]  = '{0, 4'hf, 8'hff, 32'h33323130, 1, 0, 2'd2, 32'h00000000, 3'd2, 0};
    tbl[8]  = '{0, 4'h0, 8'h00, 32'h00000000, 1, 0, 2'd2, 32'h00000000, 3'd2, 0};
    tbl[9]  = '{0, 4'hf, 8'haa, 32'h23222120, 1, 1, 2'd2, 32'h23222120, 3'd2, 0};
    tbl[10] = '{0, 4'h0, 8'h00, 32'h00000000, 1, 1, 2'd3, 32'h33323130, 3'd3, 0};
    tbl[11] = '{0, 4'h0, 8'h00, 32'h00000000, 1, 0, 2'd0, 32'h04030201, 3'd4, 1};
    tbl[12] = '{1, 4'h0, 8'h00, 32'h00000000, 1, 0, 2'd0, 32'h04030201, 3'd0, 0};

    reset = 1'b0; start = 1'b0; row_wr_en = '0;
    row_wraddr = '0; row_data_in = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_row", out_row, 2'd0);
    chk("rst_rows_done", rows_done, 3'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].st, tbl[i].en, tbl[i].ad, tbl[i].dt, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_row", i), out_row, tbl[i].er);
      chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("tbl%0d_rows_done", i), rows_done, tbl[i].erd);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].edn);
    end

    step(0, 4'hf, 8'h00, 32'ha3a2a1a0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 4'h0, 8'h00, 32'h0, 0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 32'ha3a2a1a0);
      chk("bp_rows_done", rows_done, 3'd0);
    end
    step(0, 4'h0, 8'h00, 32'h0, 1);
    chk("bp_xfer_rows_done", rows_done, 3'd1);
    chk("bp_xfer_valid", out_valid, 1'b0);

    step(0, 4'hf, 8'h55, 32'hb3b2b1b0, 0);
    step(0, 4'h1, 8'h01, 32'h00000055, 1);
    chk("same_edge_err", err, ERR_CHK);
    chk("same_edge_row", out_row, 2'd2);

    step(1, 4'h0, 8'h00, 32'h0, 0);
    chk("start_err", err, 1'b0);
    step(0, 4'h4, 8'h30, 32'h00110000, 0);
    step(0, 4'h4, 8'h30, 32'h00220000, 0);
    chk("dw_err", err, ERR_CHK);
    step(0, 4'hb, 8'hff, 32'h43004140, 0);
    step(0, 4'hf, 8'h00, 32'h07060504, 0);
    step(0, 4'hf, 8'h55, 32'h17161514, 0);
    step(0, 4'hf, 8'haa, 32'h27262524, 0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (out_valid && out_row == 2'd3) begin
        found = 1'b1;
        chk("dw_lane2", out_data[23:16], ERR_CHK ? 8'h11 : 8'h22);
      end else begin
        step(0, 4'h0, 8'h00, 32'h0, 1);
      end
    end
    if (!found) chk("dw_row3_seen", 1'b0, 1'b1);

    for (int k = 0; k < 300; k++) begin
      step(($urandom % 50) == 0, 4'($urandom), 8'($urandom),
           $urandom, ($urandom % 10) < 7);
    end

    reset = 1'b0;
    #2;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_rows_done", rows_done, 3'd0);
    chk("midrst_err", err, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(0, 4'h0, 8'h00, 32'h0, 1);

    for (int k = 0; k < 200; k++) begin
      step(($urandom % 60) == 0, 4'($urandom), 8'($urandom),
           $urandom, ($urandom % 10) < 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
